// File: rtl/rf_wb_scoreboard_if.sv
// Bundle between decode/issue, the two writeback producers and the RegisterFile
// write port. The scoreboard is the slave side; producers and decode are the master.
interface rf_wb_scoreboard_if;
  logic        issue_valid;
  logic [3:0]  issue_src1;
  logic [3:0]  issue_src2;
  logic        issue_use1;
  logic        issue_use2;
  logic [3:0]  issue_dst;
  logic        issue_dst_we;
  logic        issue_stall;

  logic        alu_wb_valid;
  logic [3:0]  alu_wb_reg;
  logic [15:0] alu_wb_data;
  logic        alu_wb_ready;

  logic        mem_wb_valid;
  logic [3:0]  mem_wb_reg;
  logic [15:0] mem_wb_data;
  logic        mem_wb_ready;

  logic [3:0]  rf_DstReg;
  logic        rf_WriteReg;
  logic [15:0] rf_DstData;
  logic [15:0] pending;
  logic        wb_err;

  modport master (
    output issue_valid, issue_src1, issue_src2, issue_use1, issue_use2,
           issue_dst, issue_dst_we,
           alu_wb_valid, alu_wb_reg, alu_wb_data,
           mem_wb_valid, mem_wb_reg, mem_wb_data,
    input  issue_stall, alu_wb_ready, mem_wb_ready,
           rf_DstReg, rf_WriteReg, rf_DstData, pending, wb_err
  );

  modport slave (
    input  issue_valid, issue_src1, issue_src2, issue_use1, issue_use2,
           issue_dst, issue_dst_we,
           alu_wb_valid, alu_wb_reg, alu_wb_data,
           mem_wb_valid, mem_wb_reg, mem_wb_data,
    output issue_stall, alu_wb_ready, mem_wb_ready,
           rf_DstReg, rf_WriteReg, rf_DstData, pending, wb_err
  );
endinterface

// File: rtl/rf_wb_scoreboard.sv
// Round-robin arbiter for the single RegisterFile write port (ALU vs. load
// writeback) plus a pending-producer scoreboard that stalls decode on RAW/WAW.
module rf_wb_scoreboard (
  input  logic                clk,
  input  logic                rst,
  rf_wb_scoreboard_if.slave   wb
);
  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  logic        lastGrantReg;
  logic        lastGrantNext;
  logic [15:0] pendingReg;
  logic [15:0] pendingNext;
  logic [3:0]  dstRegReg;
  logic        writeRegReg;
  logic [15:0] dstDataReg;
  logic        wbErrReg;

  logic        aluGrant;
  logic        memGrant;
  logic        xfer;
  logic [3:0]  wbReg;
  logic [15:0] wbData;
  logic        issueStall;
  logic        issueFire;
  logic [15:0] clrMask;
  logic [15:0] setMask;

  // Readies are forced low while reset is asserted so nothing is accepted.
  always_comb begin
    aluGrant = 1'b0;
    memGrant = 1'b0;
    if (rst) begin
      if (wb.alu_wb_valid && wb.mem_wb_valid) begin
        aluGrant = (lastGrantReg == GRANT_MEM);
        memGrant = (lastGrantReg == GRANT_ALU);
      end else begin
        aluGrant = wb.alu_wb_valid;
        memGrant = wb.mem_wb_valid;
      end
    end
  end

  always_comb begin
    lastGrantNext = lastGrantReg;
    if (aluGrant) begin
      lastGrantNext = GRANT_ALU;
    end else if (memGrant) begin
      lastGrantNext = GRANT_MEM;
    end
  end

  assign xfer   = aluGrant || memGrant;
  assign wbReg  = aluGrant ? wb.alu_wb_reg  : wb.mem_wb_reg;
  assign wbData = aluGrant ? wb.alu_wb_data : wb.mem_wb_data;

  assign issueStall = wb.issue_valid &&
                      ((wb.issue_use1   && pendingReg[wb.issue_src1]) ||
                       (wb.issue_use2   && pendingReg[wb.issue_src2]) ||
                       (wb.issue_dst_we && pendingReg[wb.issue_dst]));
  assign issueFire  = wb.issue_valid && wb.issue_dst_we && !issueStall;

  // Per-register update; a set on the same edge as a clear leaves the bit at 1.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : gPending
      assign clrMask[gi]     = xfer && (wbReg == 4'(gi));
      assign setMask[gi]     = issueFire && (wb.issue_dst == 4'(gi));
      assign pendingNext[gi] = setMask[gi] || (pendingReg[gi] && !clrMask[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastGrantReg <= GRANT_MEM;
      pendingReg   <= '0;
      dstRegReg    <= '0;
      writeRegReg  <= 1'b0;
      dstDataReg   <= '0;
      wbErrReg     <= 1'b0;
    end else begin
      lastGrantReg <= lastGrantNext;
      pendingReg   <= pendingNext;
      writeRegReg  <= xfer;
      if (xfer) begin
        dstRegReg  <= wbReg;
        dstDataReg <= wbData;
      end
      if (xfer && !pendingReg[wbReg]) begin
        wbErrReg <= 1'b1;
      end
    end
  end

  assign wb.issue_stall  = issueStall;
  assign wb.alu_wb_ready = aluGrant;
  assign wb.mem_wb_ready = memGrant;
  assign wb.rf_DstReg    = dstRegReg;
  assign wb.rf_WriteReg  = writeRegReg;
  assign wb.rf_DstData   = dstDataReg;
  assign wb.pending      = pendingReg;
  assign wb.wb_err       = wbErrReg;
endmodule
